// File: rtl/clkdiv_pkg.sv
// Shared types and default constants for the gated clock divider.
// Used by clkdiv_gate and clkdiv_cnt.
package clkdiv_pkg;

  localparam int DIV_W_DEF   = 8;
  localparam int DIV_RST_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clkdiv_cnt.sv
// Half-period counter for clkdiv_gate: counts 0..d and raises a wrap strobe when it
// reaches d. Only an equality compare is used, so d = 2^DIV_W-1 needs no extra bit.
module clkdiv_cnt
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] d_i,
  output logic             wrap_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign wrap_o = active_i && (cnt_q == d_i);

  // NOTE: cnt_d gets a value on every path before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr_i || !active_i || wrap_o) cnt_d = '0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clkdiv_gate.sv
// Gated clock divider: Y half-period = d+1 CLK cycles, clean start/stop, and glitch-free
// ratio updates via a LOAD/BUSY/ACK handshake. Optional SYNC input under CLKDIV_SYNC_EN.
module clkdiv_gate
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD,
`ifdef CLKDIV_SYNC_EN
  input  logic             SYNC,
`endif
  output logic             Y,
  output logic             BUSY,
  output logic             ACK
);

  state_e           state_q, state_d;
  logic             y_q, y_d;
  logic [DIV_W-1:0] d_cur_q, d_cur_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             wrap;
  logic             sync_req;
  logic             sync_hit;
  logic             apply;

`ifdef CLKDIV_SYNC_EN
  assign sync_req = SYNC;
`else
  assign sync_req = 1'b0;
`endif

  assign sync_hit = sync_req && (state_q != IDLE);

  clkdiv_cnt #(.DIV_W(DIV_W)) u_cnt (
    .clk      (CLK),
    .rst_n    (RN),
    .active_i (state_q != IDLE),
    .clr_i    (sync_hit || (state_d == IDLE)),
    .d_i      (d_cur_q),
    .wrap_o   (wrap)
  );

  // Stopping while high goes through DRAIN so the high phase always completes.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    case (state_q)
      IDLE:  if (EN) state_d = RUN;
      RUN: begin
        if (sync_hit)  state_d = EN ? RUN : IDLE;
        else if (!EN)  state_d = (!y_q || wrap) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (sync_hit)  state_d = EN ? RUN : IDLE;
        else if (EN)   state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE || sync_hit) y_d = 1'b0;
    else if (wrap)                   y_d = ~y_q;
  end

  // A new ratio is only adopted while stopped or on a falling wrap, so phases never shrink.
  always_comb begin
    apply   = busy_q && ((state_q == IDLE) || (wrap && y_q && !sync_hit));
    d_cur_d = apply ? pend_q : d_cur_q;
    pend_d  = LOAD ? DIV : pend_q;
    busy_d  = LOAD || (busy_q && !apply);
    ack_d   = apply;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      y_q     <= 1'b0;
      d_cur_q <= DIV_W'(DIV_RST);
      pend_q  <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      d_cur_q <= d_cur_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign Y    = y_q;
  assign BUSY = busy_q;
  assign ACK  = ack_q;

endmodule

// File: doc/clkdiv_gate.md
CLKDIV_GATE -- requirements
Module: clkdiv_gate

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the divide-ratio field.
REQ-002 SHALL have parameter DIV_RST, default 1: divide value loaded at reset.
REQ-003 SHALL have port CLK  input  1  source clock; all state on rising edge.
REQ-004 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port EN  input  1  run request for the divided clock.
REQ-006 SHALL have port DIV  input  DIV_W  divide value d; Y half-period = d+1 CLK cycles.
REQ-007 SHALL have port LOAD  input  1  one-cycle request to adopt DIV.
REQ-008 SHALL have port Y  output  1  divided clock, driven directly from a flop.
REQ-009 SHALL have port BUSY  output  1  a loaded value is pending, not yet applied.
REQ-010 SHALL have port ACK  output  1  one-cycle pulse: pending value applied.

Function
REQ-011 SHALL implement a three-state FSM: IDLE (Y=0, counter held 0), RUN, DRAIN.
REQ-012 IDLE->RUN when EN=1; counter starts at 0 with Y=0, so the first Y rise occurs d+1 cycles after the transition edge.
REQ-013 In RUN, the counter SHALL increment each cycle; when counter==d_cur it SHALL wrap to 0 and Y SHALL toggle; duty 50%, period 2*(d_cur+1) cycles.
REQ-014 d=0 SHALL give Y=CLK/2; d=2^DIV_W-1 SHALL wrap correctly with no overflow (DIV_W-bit counter, compare only).
REQ-015 RUN with EN=0: if Y=0, go to IDLE next edge; if Y=1, go to DRAIN and complete the current high phase, then Y falls at the normal wrap and the FSM enters IDLE; no truncated high pulse.
REQ-016 DRAIN with EN=1 again SHALL return to RUN seamlessly with no phase disturbance.
REQ-017 LOAD=1 SHALL capture DIV into a pending register and set BUSY the next cycle.
REQ-018 In IDLE, the pending value SHALL be applied on the next edge after capture; ACK pulses once and BUSY clears in the same cycle.
REQ-019 In RUN/DRAIN, the pending value SHALL be applied only at a wrap where Y goes 1->0, so the new ratio governs the following low phase; ACK is asserted for the cycle after that wrap.
REQ-020 LOAD while BUSY SHALL overwrite the pending value; a single ACK is issued for the last value.
REQ-021 LOAD coinciding with an apply edge SHALL apply the old pending value, ACK it, then hold the new value pending (BUSY stays 1).
REQ-022 Y SHALL never produce a high or low phase shorter than min(d_old,d_new)+1 cycles.

Reset
REQ-023 RN=0 SHALL asynchronously force: FSM=IDLE, counter=0, Y=0, BUSY=0, ACK=0, d_cur=DIV_RST, pending=0.
REQ-024 Reset deassertion SHALL take effect on CLK; reset during RUN SHALL drop Y low immediately.

Configuration
REQ-025 Macro CLKDIV_SYNC_EN defined SHALL add input SYNC (1 bit): SYNC=1 in RUN/DRAIN forces counter=0 and Y=0 on the next edge (phase realignment), without affecting BUSY/pending; in IDLE SYNC SHALL be ignored.
REQ-026 Without CLKDIV_SYNC_EN, the port SHALL be absent and behaviour SHALL be per REQ-011..022.

Structure
REQ-027 Package clkdiv_pkg SHALL hold the FSM state enum (IDLE, RUN, DRAIN) and the DIV_W/DIV_RST default constants.
REQ-028 Sub-module clkdiv_cnt SHALL hold the counter, compare and wrap strobe; the FSM, Y flop and load handshake SHALL reside in clkdiv_gate.

Verification
REQ-029 Reset, EN=1, d_cur=1 -> Y=0 for 2 cycles, then period 4, duty 2/2; BUSY=ACK=0.
REQ-030 RUN d=1, LOAD DIV=3 while Y=1 -> BUSY=1 until the Y fall; ACK one cycle later; next low phase 4 cycles, then period 8.
REQ-031 RUN d=3, EN dropped 1 cycle after Y rises -> Y stays high 4 cycles total, falls, FSM=IDLE, Y held 0.
REQ-032 Two LOADs (DIV=5, then DIV=2) before the apply point -> single ACK; half-period becomes 3.
REQ-033 RN pulsed low mid-high-phase -> Y=0 with no CLK edge; after release, d_cur=DIV_RST.
REQ-034 With CLKDIV_SYNC_EN, d=4, SYNC pulsed at counter=2 with Y=1 -> Y=0 next edge, next rise 5 cycles later.
